temp_convert_scheduler: RTL and testbench

//  Shares one bin_to_dec converter among N_SENS DS18B20 channels. Latches raw 16-bit readings
//  per sensor, grants the converter round-robin, and returns a signed BCD result tagged with
//  the sensor index. Sits between the 1-Wire/CRC readout channels and the display/output logic.
//  All sequencing advances only on F1M ticks, matching the converter timebase.

---
 rtl/temp_convert_scheduler_pkg.sv | 19 +
 rtl/temp_convert_scheduler_rr_arbiter.sv | 35 +++
 rtl/temp_convert_scheduler.sv | 154 +++++++++++++++
 tb/tb_temp_convert_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_convert_scheduler_pkg.sv
// Shared constants for the DS18B20 conversion scheduler: FSM encodings,
// default sizing and raw-word field positions.
package temp_convert_scheduler_pkg;

  localparam int N_SENS_DEF        = 4;
  localparam int IDX_W_DEF         = 2;
  localparam int TIMEOUT_TICKS_DEF = 255;

  localparam int WORD_W       = 16;
  localparam int RAW_SIGN_BIT = 11;

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_GRANT = 3'd2;
  localparam logic [2:0] ST_LOAD  = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_STORE = 3'd5;

endpackage

// File: rtl/temp_convert_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping from N_SENS-1 back to 0.
module temp_convert_scheduler_rr_arbiter #(
  parameter int N_SENS = 4,
  parameter int IDX_W  = 2
) (
  input  logic [N_SENS-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_any
);

  logic [IDX_W:0]   sum  [N_SENS];
  logic [IDX_W-1:0] cand [N_SENS];

  genvar gi;
  generate
    for (gi = 0; gi < N_SENS; gi++) begin : g_cand
      assign sum[gi]  = {1'b0, ptr} + (IDX_W+1)'(gi);
      assign cand[gi] = (sum[gi] >= (IDX_W+1)'(N_SENS)) ?
                        IDX_W'(sum[gi] - (IDX_W+1)'(N_SENS)) : sum[gi][IDX_W-1:0];
    end
  endgenerate

  // Scan farthest offset first so the nearest pending index wins.
  always_comb begin
    grant_idx = '0;
    for (int k = N_SENS - 1; k >= 0; k--) begin
      if (req[cand[k]]) grant_idx = cand[k];
    end
  end

  assign grant_any = |req;

endmodule

// File: rtl/temp_convert_scheduler.sv
// Shares one bin_to_dec converter among N_SENS DS18B20 channels: per-sensor
// capture slots, round-robin grant, F1M-paced converter handshake with timeout.
module temp_convert_scheduler
  import temp_convert_scheduler_pkg::*;
#(
  parameter int N_SENS        = N_SENS_DEF,
  parameter int IDX_W         = IDX_W_DEF,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     F1M,
  input  logic [N_SENS-1:0]        req_valid,
  input  logic [WORD_W*N_SENS-1:0] req_bin,
  output logic                     conv_en,
  output logic [WORD_W-1:0]        conv_bin,
  input  logic                     conv_done,
  input  logic [WORD_W-1:0]        conv_dec,
  output logic                     res_valid,
  output logic [IDX_W-1:0]         res_idx,
  output logic [WORD_W-1:0]        res_dec,
  output logic                     res_neg,
  output logic [N_SENS-1:0]        ovr,
  output logic                     err_to,
  output logic                     busy
);

  localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);

  logic [2:0]        state_reg;
  logic [CNT_W-1:0]  tick_cnt_reg;
  logic [IDX_W-1:0]  ptr_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              sign_reg;
  logic [WORD_W-1:0] slot_word [N_SENS];
  logic [N_SENS-1:0] pending;
  logic [N_SENS-1:0] grant_clear;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_any;
  logic              grant_fire;

  temp_convert_scheduler_rr_arbiter #(
    .N_SENS (N_SENS),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req       (pending),
    .ptr       (ptr_reg),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign grant_fire = (state_reg == ST_GRANT) && F1M && grant_any;

  // A fresh capture beats a same-clk grant clear: the new word stays queued.
  genvar gi;
  generate
    for (gi = 0; gi < N_SENS; gi++) begin : g_slot
      logic [WORD_W-1:0] word_reg;
      logic              pend_reg;
      logic              ovr_reg;

      assign grant_clear[gi] = grant_fire && (grant_idx == IDX_W'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          word_reg <= '0;
          pend_reg <= 1'b0;
          ovr_reg  <= 1'b0;
        end else begin
          ovr_reg <= req_valid[gi] && pend_reg && !grant_clear[gi];
          if (req_valid[gi]) begin
            word_reg <= req_bin[WORD_W*gi +: WORD_W];
            pend_reg <= 1'b1;
          end else if (grant_clear[gi]) begin
            pend_reg <= 1'b0;
          end
        end
      end

      assign slot_word[gi] = word_reg;
      assign pending[gi]   = pend_reg;
      assign ovr[gi]       = ovr_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_INIT;
      tick_cnt_reg <= '0;
      ptr_reg      <= '0;
      idx_reg      <= '0;
      sign_reg     <= 1'b0;
      conv_bin     <= '0;
      res_valid    <= 1'b0;
      res_idx      <= '0;
      res_dec      <= '0;
      res_neg      <= 1'b0;
      err_to       <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      err_to    <= 1'b0;
      case (state_reg)
        // The converter has no reset: let any conversion in flight drain out.
        ST_INIT: if (F1M) begin
          if (tick_cnt_reg == CNT_W'(TIMEOUT_TICKS - 1)) begin
            tick_cnt_reg <= '0;
            state_reg    <= ST_IDLE;
          end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
          end
        end
        ST_IDLE: if (F1M && (|pending)) state_reg <= ST_GRANT;
        ST_GRANT: if (F1M) begin
          if (grant_any) begin
            conv_bin  <= slot_word[grant_idx];
            sign_reg  <= slot_word[grant_idx][RAW_SIGN_BIT];
            idx_reg   <= grant_idx;
            ptr_reg   <= (grant_idx == IDX_W'(N_SENS - 1)) ? '0 : grant_idx + 1'b1;
            state_reg <= ST_LOAD;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_LOAD: if (F1M) begin
          tick_cnt_reg <= '0;
          state_reg    <= ST_WAIT;
        end
        ST_WAIT: if (F1M) begin
          if (conv_done) begin
            state_reg <= ST_STORE;
          end else if (tick_cnt_reg == CNT_W'(TIMEOUT_TICKS - 1)) begin
            err_to    <= 1'b1;
            res_idx   <= idx_reg;
            state_reg <= ST_IDLE;
          end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
          end
        end
        ST_STORE: begin
          res_valid <= 1'b1;
          res_dec   <= conv_dec;
          res_neg   <= sign_reg;
          res_idx   <= idx_reg;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_INIT;
      endcase
    end
  end

  assign conv_en = (state_reg == ST_LOAD) && !rst;
  assign busy    = (state_reg != ST_IDLE) && !rst;

endmodule

// File: tb/tb_temp_convert_scheduler.sv
// Randomized bench for temp_convert_scheduler with a behavioural converter and
// a queue-level scheduling model (pending set + round-robin pointer).
module tb_temp_convert_scheduler;

  localparam int N       = 4;
  localparam int IDX_W   = 2;
  localparam int F1M_DIV = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             F1M = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [16*N-1:0]  req_bin = '0;
  logic             conv_en;
  logic [15:0]      conv_bin;
  logic             conv_done = 1'b0;
  logic [15:0]      conv_dec = '0;
  logic             res_valid;
  logic [IDX_W-1:0] res_idx;
  logic [15:0]      res_dec;
  logic             res_neg;
  logic [N-1:0]     ovr;
  logic             err_to;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  temp_convert_scheduler #(.N_SENS(N), .IDX_W(IDX_W), .TIMEOUT_TICKS(255)) dut (
    .clk(clk), .rst(rst), .F1M(F1M), .req_valid(req_valid), .req_bin(req_bin),
    .conv_en(conv_en), .conv_bin(conv_bin), .conv_done(conv_done), .conv_dec(conv_dec),
    .res_valid(res_valid), .res_idx(res_idx), .res_dec(res_dec), .res_neg(res_neg),
    .ovr(ovr), .err_to(err_to), .busy(busy)
  );

  // Reference arithmetic: DS18B20 word -> integer degrees and BCD (tenths rounded)
  function automatic int ref_int(input logic [15:0] w);
    logic [15:0] mag;
    mag = w[11] ? (16'h0000 - w) : w;
    return int'(mag >> 4);
  endfunction

  function automatic logic [15:0] ref_bcd(input logic [15:0] w);
    logic [15:0] mag;
    int ip, tenths;
    mag    = w[11] ? (16'h0000 - w) : w;
    ip     = int'(mag >> 4);
    tenths = (int'(mag[3:0]) * 10 + 8) / 16;
    return {4'(ip / 100), 4'((ip / 10) % 10), 4'(ip % 10), 4'(tenths)};
  endfunction

  // Converter model + F1M generator
  bit          tick_seen = 0;
  bit          en_seen = 0;
  bit          hang = 0;
  int          remaining = 0;
  logic [15:0] conv_word = '0;
  int          f1m_phase = 0;
  int          lat = 0;
  int          tick_total = 0;

  always @(posedge clk) begin
    tick_seen = F1M;
    en_seen   = conv_en;
    if (F1M) begin
      tick_total++;
      if (conv_en) lat = 0;
      else lat++;
    end
  end

  always @(negedge clk) begin
    if (tick_seen) begin
      conv_done = 1'b0;
      if (en_seen) begin
        conv_word = conv_bin;
        remaining = hang ? -1 : ref_int(conv_bin) + 1;
      end else if (remaining > 0) begin
        remaining--;
        if (remaining == 0) begin
          conv_dec  = ref_bcd(conv_word);
          conv_done = 1'b1;
        end
      end
    end
    f1m_phase = (f1m_phase + 1) % F1M_DIV;
    F1M = (f1m_phase == 0);
  end

  // Scheduling model: which sensors hold an unserved word, and where rr resumes
  bit          m_pend [N];
  logic [15:0] m_word [N];
  int          m_ptr = 0;

  function automatic int m_next();
    for (int k = 0; k < N; k++) if (m_pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_pend[i] = 0;
    m_ptr = 0;
  endtask

  task automatic model_take(output int eidx, output logic [15:0] eword);
    eidx = m_next();
    eword = '0;
    if (eidx >= 0) begin
      eword = m_word[eidx];
      m_pend[eidx] = 0;
      m_ptr = (eidx + 1) % N;
    end
  endtask

  // Called on a negedge; drives a one-clk request pulse and returns on the next negedge.
  task automatic pulse(input logic [N-1:0] mask, input logic [16*N-1:0] words,
                       output logic [N-1:0] exp_ovr);
    exp_ovr = '0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        if (m_pend[i]) exp_ovr[i] = 1'b1;
        m_pend[i] = 1;
        m_word[i] = words[16*i +: 16];
      end
    end
    req_valid = mask;
    req_bin   = words;
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic wait_event(output bit got, output bit was_err, output logic [IDX_W-1:0] idx,
                            output logic [15:0] dec, output logic neg, output int l);
    got = 0; was_err = 0; idx = '0; dec = '0; neg = 1'b0; l = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (res_valid || err_to) begin
        got = 1; was_err = err_to; idx = res_idx; dec = res_dec; neg = res_neg; l = lat;
        return;
      end
    end
  endtask

  function automatic logic [15:0] rand_word();
    logic [11:0] v;
    v = 12'($urandom_range(0, 4095));
    return {{4{v[11]}}, v};
  endfunction

  task automatic test_reset();
    int t0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({res_valid, err_to, conv_en, busy, ovr, res_dec} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h required=0", {res_valid, err_to, conv_en, busy, ovr, res_dec});
    end
    model_reset();
    t0 = tick_total;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL init_busy got=%b required=1", busy); end
    for (int c = 0; c < 3000 && busy !== 1'b0; c++) @(negedge clk);
    checks++;
    if (tick_total - t0 !== 255) begin
      errors++; $display("FAIL init_ticks got=%0d required=255", tick_total - t0);
    end
    $display("reset: init lasted %0d ticks", tick_total - t0);
  endtask

  task automatic test_single();
    logic [N-1:0] eo; bit got, er; logic [IDX_W-1:0] idx; logic [15:0] dec, w; logic neg; int l, ei;
    pulse(4'b0001, {48'h0, 16'h0191}, eo);
    checks++; if (ovr !== eo) begin errors++; $display("FAIL single_ovr got=%b required=%b", ovr, eo); end
    wait_event(got, er, idx, dec, neg, l);
    model_take(ei, w);
    checks++; if (!got || er) begin errors++; $display("FAIL single_event got=%0d err=%0d required got=1 err=0", got, er); end
    checks++; if (int'(idx) !== ei) begin errors++; $display("FAIL single_idx got=%0d required=%0d", idx, ei); end
    checks++; if (dec !== 16'h0251) begin errors++; $display("FAIL single_dec got=%h required=0251", dec); end
    checks++; if (neg !== 1'b0) begin errors++; $display("FAIL single_neg got=%b required=0", neg); end
    checks++; if (l !== ref_int(w) + 2) begin errors++; $display("FAIL single_latency got=%0d required=%0d", l, ref_int(w) + 2); end
    $display("single: idx=%0d dec=%h neg=%b lat=%0d", idx, dec, neg, l);
  endtask

  task automatic test_negative();
    logic [N-1:0] eo; bit got, er; logic [IDX_W-1:0] idx; logic [15:0] dec, w; logic neg; int l, ei;
    pulse(4'b0100, {16'h0, 16'hFF5E, 32'h0}, eo);
    checks++; if (ovr !== eo) begin errors++; $display("FAIL neg_ovr got=%b required=%b", ovr, eo); end
    wait_event(got, er, idx, dec, neg, l);
    model_take(ei, w);
    checks++; if (!got || er) begin errors++; $display("FAIL neg_event got=%0d err=%0d required got=1 err=0", got, er); end
    checks++; if (int'(idx) !== ei) begin errors++; $display("FAIL neg_idx got=%0d required=%0d", idx, ei); end
    checks++; if (dec !== 16'h0101) begin errors++; $display("FAIL neg_dec got=%h required=0101", dec); end
    checks++; if (neg !== 1'b1) begin errors++; $display("FAIL neg_sign got=%b required=1", neg); end
    $display("negative: idx=%0d dec=%h neg=%b lat=%0d", idx, dec, neg, l);
  endtask

  task automatic test_fairness();
    logic [N-1:0] eo; bit got, er; logic [IDX_W-1:0] idx; logic [15:0] dec, w; logic neg; int l, ei;
    logic [16*N-1:0] words;
    // Serve sensor 3 first so the rr pointer sits at 0.
    pulse(4'b1000, {16'h0123, 48'h0}, eo);
    wait_event(got, er, idx, dec, neg, l);
    model_take(ei, w);
    checks++; if (int'(idx) !== ei) begin errors++; $display("FAIL fair_pre_idx got=%0d required=%0d", idx, ei); end
    for (int i = 0; i < N; i++) words[16*i +: 16] = rand_word();
    pulse(4'b1111, words, eo);
    checks++; if (ovr !== eo) begin errors++; $display("FAIL fair_ovr got=%b required=%b", ovr, eo); end
    for (int r = 0; r < 5; r++) begin
      wait_event(got, er, idx, dec, neg, l);
      model_take(ei, w);
      checks++;
      if (!got || er || int'(idx) !== ei || dec !== ref_bcd(w) || neg !== w[11]) begin
        errors++;
        $display("FAIL fair_result n=%0d got idx=%0d dec=%h neg=%b ev=%0d err=%0d required idx=%0d dec=%h neg=%b",
                 r, idx, dec, neg, got, er, ei, ref_bcd(w), w[11]);
      end
      $display("fairness: n=%0d idx=%0d dec=%h neg=%b", r, idx, dec, neg);
      if (r == 0) begin
        words = '0;
        words[15:0] = rand_word();
        words[63:48] = rand_word();
        pulse(4'b1001, words, eo);
        checks++; if (ovr !== eo) begin errors++; $display("FAIL fair_repulse_ovr got=%b required=%b", ovr, eo); end
      end
    end
  endtask

  task automatic test_boundaries();
    logic [N-1:0] eo; bit got, er; logic [IDX_W-1:0] idx; logic [15:0] dec, w; logic neg; int l, ei;
    pulse(4'b0001, {48'h0, 16'h07D0}, eo);
    wait_event(got, er, idx, dec, neg, l);
    model_take(ei, w);
    checks++; if (!got || int'(idx) !== ei || dec !== 16'h1250) begin
      errors++; $display("FAIL bound_max got idx=%0d dec=%h required idx=%0d dec=1250", idx, dec, ei);
    end
    $display("boundary max: idx=%0d dec=%h lat=%0d", idx, dec, l);
    pulse(4'b0010, {32'h0, 16'h0000, 16'h0}, eo);
    wait_event(got, er, idx, dec, neg, l);
    model_take(ei, w);
    checks++; if (!got || int'(idx) !== ei || dec !== 16'h0000) begin
      errors++; $display("FAIL bound_zero got idx=%0d dec=%h required idx=%0d dec=0000", idx, dec, ei);
    end
    checks++; if (l !== 2) begin errors++; $display("FAIL bound_zero_latency got=%0d required=2", l); end
    $display("boundary zero: idx=%0d dec=%h lat=%0d", idx, dec, l);
    pulse(4'b0010, {32'h0, 16'h0050, 16'h0}, eo);
    pulse(4'b0010, {32'h0, 16'h0320, 16'h0}, eo);
    checks++; if (ovr !== eo || eo !== 4'b0010) begin
      errors++; $display("FAIL bound_ovr got=%b required=%b", ovr, 4'b0010);
    end
    wait_event(got, er, idx, dec, neg, l);
    model_take(ei, w);
    checks++; if (!got || int'(idx) !== ei || dec !== ref_bcd(16'h0320)) begin
      errors++; $display("FAIL bound_ovr_word got idx=%0d dec=%h required idx=%0d dec=%h", idx, dec, ei, ref_bcd(16'h0320));
    end
    $display("boundary ovr: idx=%0d dec=%h", idx, dec);
  endtask

  task automatic test_timeout();
    logic [N-1:0] eo; bit got, er; logic [IDX_W-1:0] idx; logic [15:0] dec, w; logic neg; int l, ei;
    hang = 1;
    pulse(4'b0101, {16'h0, 16'h0190, 16'h0, 16'h0230}, eo);
    wait_event(got, er, idx, dec, neg, l);
    model_take(ei, w);
    checks++; if (!got || !er || int'(idx) !== ei) begin
      errors++; $display("FAIL timeout_event got ev=%0d err=%0d idx=%0d required ev=1 err=1 idx=%0d", got, er, idx, ei);
    end
    checks++; if (l !== 255) begin errors++; $display("FAIL timeout_ticks got=%0d required=255", l); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle got busy=%b required=0", busy); end
    $display("timeout: idx=%0d ticks=%0d", idx, l);
    hang = 0;
    wait_event(got, er, idx, dec, neg, l);
    model_take(ei, w);
    checks++; if (!got || er || int'(idx) !== ei || dec !== ref_bcd(w)) begin
      errors++; $display("FAIL timeout_next got idx=%0d dec=%h err=%0d required idx=%0d dec=%h err=0", idx, dec, er, ei, ref_bcd(w));
    end
    $display("after timeout: idx=%0d dec=%h", idx, dec);
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] eo; bit got, er; logic [IDX_W-1:0] idx; logic [15:0] dec, w; logic neg; int l, ei, t0;
    pulse(4'b0010, {32'h0, 16'h0550, 16'h0}, eo);
    for (int c = 0; c < 200 && conv_en !== 1'b1; c++) @(negedge clk);
    for (int c = 0; c < 200 && conv_en !== 1'b0; c++) @(negedge clk);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (conv_en !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got conv_en=%b busy=%b required 0 0", conv_en, busy);
    end
    repeat (2) @(negedge clk);
    model_reset();
    t0 = tick_total;
    rst = 1'b0;
    pulse(4'b1000, {16'h0199, 48'h0}, eo);
    wait_event(got, er, idx, dec, neg, l);
    model_take(ei, w);
    checks++; if (!got || er || int'(idx) !== ei || dec !== ref_bcd(w)) begin
      errors++; $display("FAIL midrst_served got idx=%0d dec=%h err=%0d required idx=%0d dec=%h err=0", idx, dec, er, ei, ref_bcd(w));
    end
    checks++; if (tick_total - t0 < 255) begin
      errors++; $display("FAIL midrst_init got result after %0d ticks required at least 255", tick_total - t0);
    end
    $display("mid reset: idx=%0d dec=%h after %0d ticks", idx, dec, tick_total - t0);
  endtask

  task automatic test_random();
    logic [N-1:0] eo, mask; bit got, er; logic [IDX_W-1:0] idx; logic [15:0] dec, w; logic neg; int l, ei;
    logic [16*N-1:0] words;
    for (int rnd = 0; rnd < 5; rnd++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) words[16*i +: 16] = rand_word();
      pulse(mask, words, eo);
      checks++; if (ovr !== eo) begin errors++; $display("FAIL rand_ovr got=%b required=%b", ovr, eo); end
      for (int n = 0; n < 12 && m_next() >= 0; n++) begin
        wait_event(got, er, idx, dec, neg, l);
        model_take(ei, w);
        checks++;
        if (!got || er || int'(idx) !== ei || dec !== ref_bcd(w) || neg !== w[11] || l !== ref_int(w) + 2) begin
          errors++;
          $display("FAIL rand_result got idx=%0d dec=%h neg=%b lat=%0d ev=%0d err=%0d required idx=%0d dec=%h neg=%b lat=%0d",
                   idx, dec, neg, l, got, er, ei, ref_bcd(w), w[11], ref_int(w) + 2);
        end
        $display("random: round=%0d idx=%0d word=%h dec=%h neg=%b lat=%0d", rnd, idx, w, dec, neg, l);
        if ($urandom_range(0, 2) == 0) begin
          mask = N'($urandom_range(1, (1 << N) - 1));
          for (int i = 0; i < N; i++) words[16*i +: 16] = rand_word();
          pulse(mask, words, eo);
          checks++; if (ovr !== eo) begin errors++; $display("FAIL rand_repulse_ovr got=%b required=%b", ovr, eo); end
        end
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_word[i] = '0; end
    test_reset();
    test_single();
    test_negative();
    test_fairness();
    test_boundaries();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
